// File: rtl/alu_sequencer.sv
// alu_sequencer: queues ALU commands, issues them one at a time and holds each result until the consumer takes it
module alu_sequencer #(
    parameter int DEPTH   = 4,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [4:0]  cmd_opcode,
    input  logic [31:0] cmd_a,
    input  logic [31:0] cmd_b,
    output logic [4:0]  opcode,
    output logic [31:0] a,
    output logic [31:0] b,
    output logic        enable,
    input  logic [31:0] out,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic [4:0]  res_opcode,
    output logic        busy,
    output logic [15:0] issued
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;
    state_t state, state_d;
    logic [4:0]    mem_op [DEPTH];
    logic [31:0]   mem_a  [DEPTH];
    logic [31:0]   mem_b  [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [3:0]    wcnt;
    logic          armed, push, pop, capture;
    assign cmd_ready = count != FULL;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = armed && state == IDLE && count != '0;
    assign capture   = state == WAIT && wcnt == 4'd1;
    assign busy      = state != IDLE || count != '0;
    // the FSM only starts moving one edge after reset release
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) armed <= 1'b0;
        else armed <= 1'b1;
    always_ff @(posedge clk)
        if (push) begin
            mem_op[wr_ptr] <= cmd_opcode;
            mem_a[wr_ptr]  <= cmd_a;
            mem_b[wr_ptr]  <= cmd_b;
        end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_d;
    always_comb begin
        state_d = state;
        if (armed)
            case (state)
                IDLE:    state_d = (count != '0) ? ISSUE : IDLE;
                ISSUE:   state_d = WAIT;
                WAIT:    state_d = capture ? HOLD : WAIT;
                HOLD:    state_d = res_ready ? IDLE : HOLD;
                default: state_d = IDLE;
            endcase
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            enable     <= 1'b0;
            opcode     <= '0;
            a          <= '0;
            b          <= '0;
            wcnt       <= '0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_opcode <= '0;
            issued     <= '0;
        end else begin
            enable <= pop;
            if (pop) begin
                opcode <= mem_op[rd_ptr];
                a      <= mem_a[rd_ptr];
                b      <= mem_b[rd_ptr];
            end
            if (state == ISSUE) begin
                wcnt   <= 4'(LATENCY);
                issued <= issued + 16'd1;
            end else if (state == WAIT) wcnt <= wcnt - 4'd1;
            if (capture) begin
                res_data   <= out;
                res_opcode <= opcode;
                res_valid  <= 1'b1;
            end else if (state == HOLD && res_ready) res_valid <= 1'b0;
        end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed stimulus with a result scoreboard against an a-b ALU model of fixed latency
module tb_alu_sequencer;
    localparam int DEPTH = 4;
    localparam int LAT   = 3;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [4:0]  cmd_opcode = '0;
    logic [31:0] cmd_a = '0;
    logic [31:0] cmd_b = '0;
    logic [4:0]  opcode, res_opcode;
    logic [31:0] a, b, out, res_data;
    logic        enable, res_valid, busy;
    logic        res_ready = 1'b0;
    logic [15:0] issued;
    int total = 0, bad = 0, cyc = 0, alu_cnt = 0, res_seen = 0;
    typedef struct packed { logic [4:0] op; logic [31:0] d; } exp_t;
    exp_t exp_q[$];
    exp_t e;
    int en_cyc[$];
    int valid_cyc[$];
    logic [4:0] en_op[$];
    logic [4:0] b2b_ops [4] = '{5'd14, 5'd15, 5'd2, 5'd3};
    logic prev_valid = 1'b0;

    alu_sequencer #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .opcode(opcode), .a(a), .b(b), .enable(enable), .out(out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_opcode(res_opcode), .busy(busy), .issued(issued)
    );

    always #5 clk = ~clk;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        alu_cnt <= enable ? 1 : (alu_cnt != 0 ? alu_cnt + 1 : 0);
    end
    // result is only correct exactly LAT cycles after the enable cycle
    assign out = (alu_cnt == LAT) ? a - b : 32'hDEAD_BEEF;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (enable) begin
            en_cyc.push_back(cyc);
            en_op.push_back(opcode);
        end
        if (res_valid && !prev_valid) valid_cyc.push_back(cyc);
        prev_valid = res_valid;
        if (res_valid && res_ready) begin
            if (exp_q.size() == 0) check("unexpected_result", 1, 0);
            else begin
                e = exp_q.pop_front();
                check("res_data", res_data, e.d);
                check("res_opcode", res_opcode, e.op);
            end
            res_seen++;
        end
    end

    task automatic push(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y, output int c);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_opcode = op;
        cmd_a = x;
        cmd_b = y;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        c = cyc;
        if (cmd_ready) exp_q.push_back(exp_t'({op, x - y}));
        else check("push_timeout", 0, 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_seen(input int target);
        int k = 0;
        while (res_seen < target && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (res_seen < target) check("result_timeout", res_seen, target);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: run did not complete, bad=%0d", bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c, n0, k;
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_enable", enable, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_issued", issued, 0);
        check("rst_opcode", opcode, 0);
        check("rst_a", a, 0);
        check("rst_b", b, 0);
        check("rst_res_data", res_data, 0);
        check("rst_res_opcode", res_opcode, 0);
        #2 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        res_ready = 1'b1;
        push(5'd2, 32'd4528, 32'd4500, c);
        wait_seen(1);
        check("single_en_count", en_cyc.size(), 1);
        if (en_cyc.size() > 0) check("single_en_cycle", en_cyc[0], c + 2);
        check("single_valid_count", valid_cyc.size(), 1);
        if (valid_cyc.size() > 0) check("single_valid_cycle", valid_cyc[0], c + 3 + LAT);
        check("single_issued", issued, 1);
        en_cyc.delete();
        en_op.delete();
        n0 = res_seen;
        push(5'd14, 32'd100, 32'd1, c);
        push(5'd15, 32'd200, 32'd2, c);
        push(5'd2, 32'd300, 32'd3, c);
        push(5'd3, 32'd400, 32'd4, c);
        wait_seen(n0 + 4);
        check("b2b_en_count", en_cyc.size(), 4);
        for (int i = 1; i < en_cyc.size(); i++) check("b2b_period", en_cyc[i] - en_cyc[i-1], LAT + 3);
        for (int i = 0; i < en_op.size() && i < 4; i++) check("b2b_opcode", en_op[i], b2b_ops[i]);
        check("b2b_issued", issued, 5);
        res_ready = 1'b0;
        en_cyc.delete();
        n0 = res_seen;
        push(5'd7, 32'd1000, 32'd1, c);
        push(5'd8, 32'd2000, 32'd2, c);
        push(5'd9, 32'd3000, 32'd3, c);
        push(5'd10, 32'd4000, 32'd4, c);
        push(5'd11, 32'd5000, 32'd5, c);
        @(negedge clk);
        check("full_cmd_ready", cmd_ready, 0);
        k = 0;
        while (!res_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        for (int i = 0; i < 10; i++) begin
            check("hold_data", res_data, 999);
            check("hold_opcode", res_opcode, 7);
            check("hold_valid", res_valid, 1);
            check("hold_enable", enable, 0);
            check("hold_cmd_ready", cmd_ready, 0);
            @(negedge clk);
        end
        check("hold_no_issue", en_cyc.size(), 1);
        fork
            push(5'd12, 32'd6000, 32'd6, c);
            begin
                @(posedge clk);
                #1 res_ready = 1'b1;
            end
        join
        wait_seen(n0 + 6);
        check("fill_en_count", en_cyc.size(), 6);
        check("fill_issued", issued, 11);
        en_cyc.delete();
        n0 = res_seen;
        push(5'd20, 32'd50, 32'd5, c);
        push(5'd21, 32'd60, 32'd6, c);
        k = 0;
        while (en_cyc.size() == 0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rstw_enable", enable, 0);
        check("rstw_res_valid", res_valid, 0);
        check("rstw_cmd_ready", cmd_ready, 1);
        check("rstw_busy", busy, 0);
        check("rstw_issued", issued, 0);
        exp_q.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("rstw_no_result", res_seen, n0);
        check("rstw_no_issue", en_cyc.size(), 1);
        @(posedge clk);
        #1 force dut.issued = 16'hFFFE;
        #1 release dut.issued;
        n0 = res_seen;
        push(5'd30, 32'd77, 32'd7, c);
        wait_seen(n0 + 1);
        check("wrap_ffff", issued, 16'hFFFF);
        push(5'd31, 32'd88, 32'd8, c);
        wait_seen(n0 + 2);
        check("wrap_zero", issued, 16'h0000);
        repeat (5) @(negedge clk);
        check("drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter DEPTH, default 4, command FIFO entries; power of two, 2..16.
REQ-002 Parameter LATENCY, default 1, ALU cycles from enable sample edge to valid out; 1..15.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  FIFO can accept; equals (count != DEPTH), from registered count.
REQ-007 cmd_opcode  input  5  opcode to issue.
REQ-008 cmd_a, cmd_b  input  32 each  operands.
REQ-009 opcode  output  5  to ALU opcode port.
REQ-010 a, b  output  32 each  to ALU operand ports.
REQ-011 enable  output  1  to ALU enable; registered.
REQ-012 out  input  32  ALU result.
REQ-013 res_valid  output  1  result available.
REQ-014 res_ready  input  1  consumer accepts result.
REQ-015 res_data  output  32  captured ALU result.
REQ-016 res_opcode  output  5  opcode that produced res_data.
REQ-017 busy  output  1  high in any state but IDLE, or FIFO non-empty.
REQ-018 issued  output  16  count of enable pulses, wraps 0xFFFF->0x0000.

Function
REQ-019 Command accepted on rising edge with cmd_valid && cmd_ready; written to FIFO tail; no bypass.
REQ-020 At full, push refused even if a pop happens the same cycle; pop and push same cycle when not full: count unchanged, both take effect.
REQ-021 FIFO pointers wrap modulo DEPTH; order strictly FIFO.
REQ-022 FSM states IDLE, ISSUE, WAIT, HOLD; reset state IDLE.
REQ-023 IDLE, FIFO non-empty: pop head into opcode/a/b registers, enable<=1, ->ISSUE; else stay, enable 0.
REQ-024 ISSUE: enable high exactly this one cycle (cycle T); load wait counter with LATENCY; ->WAIT; issued increments at this edge.
REQ-025 WAIT: counter decrements each cycle; at edge ending cycle T+LATENCY capture out into res_data, opcode into res_opcode, res_valid<=1, ->HOLD.
REQ-026 opcode/a/b held stable from T until next pop; enable 0 outside ISSUE.
REQ-027 HOLD: res_valid, res_data, res_opcode stable until res_ready; on handshake edge res_valid<=0, ->IDLE.
REQ-028 Latencies: accept edge ending cycle C -> enable high in C+2; res_valid first high in T+LATENCY+1; back-to-back issue period LATENCY+3 cycles when res_ready held high.
REQ-029 res_ready ignored outside HOLD; cmd accepted in any state while not full.
REQ-030 out sampled only at the REQ-025 edge; values on other cycles ignored.

Reset
REQ-031 rst_n low asynchronously forces: state IDLE, FIFO empty (count 0, pointers 0), enable 0, opcode 0, a 0, b 0, res_valid 0, res_data 0, res_opcode 0, issued 0, cmd_ready 1, busy 0.
REQ-032 Reset mid-operation (ISSUE/WAIT/HOLD) discards pending and in-flight results; no res_valid after release until a new command completes.
REQ-033 Release synchronous in effect: first state change at earliest on second rising edge after rst_n rises.

Verification
REQ-034 Single op, LATENCY=1, ALU model out=a-b: push opcode 2, a=4528, b=4500 at C -> enable only in C+2, res_valid in C+4, res_data=28, res_opcode=2, issued=1.
REQ-035 Fill: DEPTH=4, res_ready=0, push 6 commands -> cmd_ready low once count=4; after first pop, fifth accepted; results emerge in push order, none lost or duplicated.
REQ-036 Backpressure: hold res_ready=0 for 10 cycles in HOLD -> res_data/res_opcode constant, enable stays 0, no further issue until handshake.
REQ-037 Back-to-back, LATENCY=3, res_ready=1, 4 queued ops (opcodes 14,15,2,3) -> enable pulses exactly 6 cycles apart, opcodes in order, issued=4.
REQ-038 Reset in WAIT: assert rst_n low mid-cycle -> enable, res_valid, count 0 immediately; no result after release.
REQ-039 Wrap: preload 65535 ops (or force) -> issued reads 0xFFFF then 0x0000 after next enable.
